// File: rtl/fmul32_pkg.sv
// Shared definitions for the FMUL32 datapath: result-class indices, widths,
// the multiplier FSM encoding and small operand-field helpers.
package fmul32_pkg;

  localparam int POS_ZERO   = 0;
  localparam int POS_NORM   = 1;
  localparam int POS_DENORM = 2;
  localparam int POS_INF    = 3;
  localparam int POS_NAN    = 4;

  localparam int MARK_W   = 5;
  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Denormals behave as if their exponent were 1.
  function automatic logic [7:0] eff_exp(input logic [7:0] e);
    if (e == 8'd0) begin
      return 8'd1;
    end else begin
      return e;
    end
  endfunction

  function automatic logic hidden_bit(input logic [7:0] e);
    return (e != 8'd0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/mant_shift_add.sv
// Radix-2 shift-and-add significand multiplier core: multiplicand, multiplier,
// accumulator and step counter, advanced one partial product per step.
module mant_shift_add #(
  parameter int MANT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [MANT_W-1:0]     op_a,
  input  logic [MANT_W-1:0]     op_b,
  output logic [2*MANT_W-1:0]   acc_next,
  output logic                  last
);

  localparam int CNT_W = $clog2(MANT_W);

  logic [2*MANT_W-1:0] a_r;
  logic [MANT_W-1:0]   b_r;
  logic [2*MANT_W-1:0] acc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2*MANT_W-1:0] acc_next_s;

  // Accumulator value after the current step's conditional add.
  always_comb begin
    acc_next_s = acc_r;
    if (b_r[0]) begin
      acc_next_s = acc_r + a_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  assign acc_next = acc_next_s;
  assign last     = (cnt_r == CNT_W'(MANT_W - 1));

  // Operand load and per-step shift/accumulate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      acc_r <= '0;
      cnt_r <= '0;
    end else if (load) begin
      a_r   <= {{MANT_W{1'b0}}, op_a};
      b_r   <= op_b;
      acc_r <= '0;
      cnt_r <= '0;
    end else if (step) begin
      acc_r <= acc_next_s;
      a_r   <= a_r << 1;
      b_r   <= b_r >> 1;
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      a_r   <= a_r;
      b_r   <= b_r;
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/fmul32_mant_mul.sv
// FMUL32 significand multiplier and exponent adder: sequential 24-step product
// for normal operands, one-cycle bypass for NaN/Inf/Zero results.
module fmul32_mant_mul #(
  parameter int MANT_W   = fmul32_pkg::MANT_W,
  parameter int EXP_BIAS = fmul32_pkg::EXP_BIAS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    op1_exp,
  input  logic [7:0]                    op2_exp,
  input  logic [MANT_W-2:0]             op1_mant,
  input  logic [MANT_W-2:0]             op2_mant,
  input  logic                          res_sign,
  input  logic [fmul32_pkg::MARK_W-1:0] res_mark,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sign,
  output logic [fmul32_pkg::MARK_W-1:0] out_mark,
  output logic signed [9:0]             out_exp,
  output logic [2*MANT_W-1:0]           out_prod
);

  import fmul32_pkg::*;

  mul_state_e            state_r;
  mul_state_e            next_state_s;
  logic                  load_s;
  logic                  step_s;
  logic                  special_s;
  logic                  last_s;
  logic [9:0]            exp_sum_s;
  logic [MANT_W-1:0]     op_a_s;
  logic [MANT_W-1:0]     op_b_s;
  logic [2*MANT_W-1:0]   acc_next_s;

  logic                  out_sign_r;
  logic [MARK_W-1:0]     out_mark_r;
  logic [9:0]            out_exp_r;
  logic [2*MANT_W-1:0]   out_prod_r;

  assign special_s = res_mark[POS_NAN] | res_mark[POS_INF] | res_mark[POS_ZERO];
  assign op_a_s    = {hidden_bit(op1_exp), op1_mant};
  assign op_b_s    = {hidden_bit(op2_exp), op2_mant};
  // Range is -125..381, so a 10-bit two's-complement sum never overflows.
  assign exp_sum_s = {2'b00, eff_exp(op1_exp)} + {2'b00, eff_exp(op2_exp)} - 10'(EXP_BIAS);

  mant_shift_add #(.MANT_W(MANT_W)) u_shift_add (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .step     (step_s),
    .op_a     (op_a_s),
    .op_b     (op_b_s),
    .acc_next (acc_next_s),
    .last     (last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          load_s = 1'b1;
          if (special_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_CALC;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        step_s = 1'b1;
        if (last_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Result registers: captured on accept, product filled in on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sign_r <= 1'b0;
      out_mark_r <= '0;
      out_exp_r  <= '0;
      out_prod_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            out_sign_r <= res_sign;
            out_mark_r <= res_mark;
            out_exp_r  <= special_s ? 10'd0 : exp_sum_s;
            out_prod_r <= '0;
          end
        end
        ST_CALC: begin
          if (last_s) begin
            out_prod_r <= acc_next_s;
          end
        end
        default: begin
          out_prod_r <= out_prod_r;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign out_sign  = out_sign_r;
  assign out_mark  = out_mark_r;
  assign out_exp   = out_exp_r;
  assign out_prod  = out_prod_r;

endmodule

// File: tb/tb_fmul32_mant_mul.sv
// Directed self-checking bench for fmul32_mant_mul.
module tb_fmul32_mant_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  op1_exp, op2_exp;
  logic [22:0] op1_mant, op2_mant;
  logic        res_sign;
  logic [4:0]  res_mark;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [4:0]  out_mark;
  logic [9:0]  out_exp;
  logic [47:0] out_prod;

  int checks = 0;
  int errors = 0;
  int lat;

  localparam logic [4:0] MK_NORM   = 5'b00010;
  localparam logic [4:0] MK_DENORM = 5'b00100;
  localparam logic [4:0] MK_NAN    = 5'b10000;

  fmul32_mant_mul dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op1_exp(op1_exp), .op2_exp(op2_exp),
    .op1_mant(op1_mant), .op2_mant(op2_mant),
    .res_sign(res_sign), .res_mark(res_mark),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_mark(out_mark),
    .out_exp(out_exp), .out_prod(out_prod)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Presents one operation for a single cycle, then counts edges until out_valid.
  task automatic issue(input logic [7:0] e1, input logic [22:0] m1,
                       input logic [7:0] e2, input logic [22:0] m2,
                       input logic s, input logic [4:0] mk, output int n);
    @(negedge clk);
    op1_exp = e1; op1_mant = m1; op2_exp = e2; op2_mant = m2;
    res_sign = s; res_mark = mk; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      in_valid = 1'b0;
    end while (!out_valid && n < 60);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {47'd0, out_valid}, 48'd0);
    chk({tag, "_ready_back"}, {47'd0, in_ready}, 48'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op1_exp = 8'd0; op2_exp = 8'd0; op1_mant = 23'd0; op2_mant = 23'd0;
    res_sign = 1'b0; res_mark = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {47'd0, in_ready}, 48'd1);
    chk("rst_out_valid", {47'd0, out_valid}, 48'd0);
    chk("rst_out_prod", out_prod, 48'd0);
    chk("rst_out_exp", {38'd0, out_exp}, 48'd0);
    chk("rst_out_mark", {43'd0, out_mark}, 48'd0);
    chk("rst_out_sign", {47'd0, out_sign}, 48'd0);
    rst = 1'b0;

    // 1.5 x 2.0
    issue(8'd127, 23'h400000, 8'd128, 23'h000000, 1'b0, MK_NORM, lat);
    chk("norm_latency", 48'(lat), 48'd25);
    chk("norm_prod", out_prod, 48'h600000000000);
    chk("norm_exp", {38'd0, out_exp}, 48'd128);
    chk("norm_mark", {43'd0, out_mark}, {43'd0, MK_NORM});
    chk("norm_sign", {47'd0, out_sign}, 48'd0);
    chk("norm_in_ready", {47'd0, in_ready}, 48'd0);
    release_out("norm");

    // Largest finite operands
    issue(8'd254, 23'h7FFFFF, 8'd254, 23'h7FFFFF, 1'b1, MK_NORM, lat);
    chk("max_latency", 48'(lat), 48'd25);
    chk("max_prod", out_prod, 48'hFFFFFE000001);
    chk("max_exp", {38'd0, out_exp}, 48'd381);
    chk("max_sign", {47'd0, out_sign}, 48'd1);
    release_out("max");

    // NaN bypass
    issue(8'd200, 23'h123456, 8'd100, 23'h654321, 1'b1, MK_NAN, lat);
    chk("nan_latency", 48'(lat), 48'd1);
    chk("nan_prod", out_prod, 48'd0);
    chk("nan_exp", {38'd0, out_exp}, 48'd0);
    chk("nan_mark", {43'd0, out_mark}, {43'd0, MK_NAN});
    chk("nan_sign", {47'd0, out_sign}, 48'd1);
    release_out("nan");

    // Denormal op1 (smallest fraction) times 1.0
    issue(8'd0, 23'h000001, 8'd127, 23'h000000, 1'b0, MK_DENORM, lat);
    chk("den_latency", 48'(lat), 48'd25);
    chk("den_prod", out_prod, 48'h000000800000);
    chk("den_exp", {38'd0, out_exp}, 48'd1);
    release_out("den");

    // Backpressure: result held, new input ignored
    issue(8'd127, 23'h400000, 8'd128, 23'h000000, 1'b0, MK_NORM, lat);
    chk("bp_latency", 48'(lat), 48'd25);
    for (int i = 0; i < 5; i++) begin
      op1_exp = 8'd1; op1_mant = 23'h000003; op2_exp = 8'd2; op2_mant = 23'h000005;
      res_sign = 1'b1; res_mark = MK_NAN; in_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid", {47'd0, out_valid}, 48'd1);
      chk("bp_in_ready", {47'd0, in_ready}, 48'd0);
      chk("bp_prod", out_prod, 48'h600000000000);
      chk("bp_exp", {38'd0, out_exp}, 48'd128);
      chk("bp_mark", {43'd0, out_mark}, {43'd0, MK_NORM});
    end
    in_valid = 1'b0;
    release_out("bp");
    issue(8'd254, 23'h7FFFFF, 8'd254, 23'h7FFFFF, 1'b0, MK_NORM, lat);
    chk("bp_next_latency", 48'(lat), 48'd25);
    chk("bp_next_prod", out_prod, 48'hFFFFFE000001);
    release_out("bp_next");

    // Reset after ten CALC steps
    @(negedge clk);
    op1_exp = 8'd127; op1_mant = 23'h400000; op2_exp = 8'd128; op2_mant = 23'h000000;
    res_sign = 1'b1; res_mark = MK_NORM; in_valid = 1'b1;
    repeat (11) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("mid_busy", {47'd0, in_ready}, 48'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_in_ready", {47'd0, in_ready}, 48'd1);
    chk("mid_out_valid", {47'd0, out_valid}, 48'd0);
    chk("mid_out_prod", out_prod, 48'd0);
    chk("mid_out_exp", {38'd0, out_exp}, 48'd0);
    chk("mid_out_mark", {43'd0, out_mark}, 48'd0);
    chk("mid_out_sign", {47'd0, out_sign}, 48'd0);
    issue(8'd127, 23'h400000, 8'd128, 23'h000000, 1'b0, MK_NORM, lat);
    chk("mid_latency", 48'(lat), 48'd25);
    chk("mid_prod", out_prod, 48'h600000000000);
    chk("mid_exp", {38'd0, out_exp}, 48'd128);
    release_out("mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
